// File: rtl/scp_079_seq_gen.sv
// Light-sequence generator: emits a captured list of g/y/r symbols as timed one-hot lamp pulses
// with optional gaps, and reports completion with a one-cycle done pulse.
module scp_079_seq_gen #(
    parameter int unsigned MAX_LEN   = 8,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 2,
    localparam int unsigned LW       = $clog2(MAX_LEN + 1),
    localparam int unsigned IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*MAX_LEN-1:0] code,
    input  logic [LW-1:0]     len,
    input  logic              abort,
    output logic              g,
    output logic              y,
    output logic              r,
    output logic              busy,
    output logic              done,
    output logic [IW-1:0]     sym_idx
);

    localparam int unsigned CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PulseLast = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GapLast   = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [2*MAX_LEN-1:0]   code_q, code_d;
    logic [LW-1:0]          len_q, len_d;
    logic [LW-1:0]          len_clamp;
    logic                   last_sym;
    logic [1:0]             sym;
    logic                   g_d, y_d, r_d, busy_d, done_d;
    logic                   g_q, y_q, r_q, busy_q, done_q;

    assign len_clamp = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
    assign last_sym  = ((LW'(idx_q) + LW'(1)) == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            len_q   <= '0;
            g_q     <= 1'b0;
            y_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            len_q   <= len_d;
            g_q     <= g_d;
            y_q     <= y_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        code_d  = code_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StPulse;
                        code_d  = code;
                        len_d   = len_clamp;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            StPulse: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == PulseLast) begin
                    cnt_d = '0;
                    if (last_sym) begin
                        state_d = StDone;
                    end else if (GAP_CYC > 0) begin
                        state_d = StGap;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == GapLast) begin
                    state_d = StPulse;
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from next-state values so the registered lamps line up with state_q.
    always_comb begin
        sym    = code_d[{idx_d, 1'b0} +: 2];
        g_d    = 1'b0;
        y_d    = 1'b0;
        r_d    = 1'b0;
        busy_d = (state_d == StPulse) || (state_d == StGap);
        done_d = (state_d == StDone);
        if (state_d == StPulse) begin
            unique case (sym)
                2'b00:   g_d = 1'b1;
                2'b01:   y_d = 1'b1;
                2'b10:   r_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign g       = g_q;
    assign y       = y_q;
    assign r       = r_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sym_idx = idx_q;

endmodule

// File: tb/tb_scp_079_seq_gen.sv
// Directed bench: instance a uses PULSE_CYC=2/GAP_CYC=1, instance b uses PULSE_CYC=2/GAP_CYC=0.
module tb_scp_079_seq_gen;

    logic        clk = 1'b0;
    logic        rst, start_a, start_b, abort;
    logic [15:0] code;
    logic [3:0]  len;
    logic        g_a, y_a, r_a, busy_a, done_a;
    logic        g_b, y_b, r_b, busy_b, done_b;
    logic [2:0]  idx_a, idx_b;
    logic [4:0]  oa, ob;
    int          total = 0;
    int          bad = 0;

    // {g,y,r,busy,done} per cycle of the G,Y,R sequence, cycle 0 = start cycle
    logic [4:0] basic_exp [0:10] = '{5'b00000, 5'b10010, 5'b10010, 5'b00010, 5'b01010, 5'b01010,
                                     5'b00010, 5'b00110, 5'b00110, 5'b00001, 5'b00000};
    logic [2:0] basic_idx [0:8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
    // BLANK then Y with no gap
    logic [4:0] zg_exp [0:6] = '{5'b00000, 5'b00010, 5'b00010, 5'b01010, 5'b01010, 5'b00001,
                                 5'b00000};

    always #5 clk = ~clk;

    assign oa = {g_a, y_a, r_a, busy_a, done_a};
    assign ob = {g_b, y_b, r_b, busy_b, done_b};

    scp_079_seq_gen #(.MAX_LEN(8), .PULSE_CYC(2), .GAP_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .code(code), .len(len), .abort(abort),
        .g(g_a), .y(y_a), .r(r_a), .busy(busy_a), .done(done_a), .sym_idx(idx_a)
    );

    scp_079_seq_gen #(.MAX_LEN(8), .PULSE_CYC(2), .GAP_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .code(code), .len(len), .abort(abort),
        .g(g_b), .y(y_b), .r(r_b), .busy(busy_b), .done(done_b), .sym_idx(idx_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Caller is at the start of cycle 0; extra starts in cycles 3 and 9 must be ignored.
    task automatic run_basic(input string name, input bit extra_starts);
        for (int c = 0; c <= 10; c++) begin
            start_a = (c == 0) || (extra_starts && (c == 3 || c == 9));
            code    = (c == 0) ? 16'h0024 : 16'hFFFF;
            len     = (c == 0) ? 4'd3 : 4'd1;
            @(negedge clk);
            chk($sformatf("%s out c%0d", name, c), 8'(oa), 8'(basic_exp[c]));
            if (c <= 8) chk($sformatf("%s idx c%0d", name, c), 8'(idx_a), 8'(basic_idx[c]));
            tick();
        end
        start_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; code = '0; len = '0;
        tick(); tick();
        @(negedge clk);
        chk("reset a", 8'(oa), 8'h00);
        chk("reset idx a", 8'(idx_a), 8'h00);
        chk("reset b", 8'(ob), 8'h00);
        tick();
        rst = 1'b0;
        tick();

        run_basic("basic", 1'b0);
        run_basic("busy_start", 1'b1);

        // Zero-gap instance: code[3:0]=0111 -> symbol 0 BLANK, symbol 1 Y
        for (int c = 0; c <= 6; c++) begin
            start_b = (c == 0);
            code    = (c == 0) ? 16'h0007 : 16'h0000;
            len     = (c == 0) ? 4'd2 : 4'd0;
            @(negedge clk);
            chk($sformatf("zero_gap out c%0d", c), 8'(ob), 8'(zg_exp[c]));
            if (c >= 1 && c <= 4) chk($sformatf("zero_gap idx c%0d", c), 8'(idx_b),
                                      (c <= 2) ? 8'd0 : 8'd1);
            tick();
        end
        start_b = 1'b0;

        // len=0
        start_a = 1'b1; len = 4'd0; code = 16'h0024;
        tick();
        start_a = 1'b0;
        @(negedge clk);
        chk("len0 c1", 8'(oa), 8'b00001);
        tick();
        @(negedge clk);
        chk("len0 c2", 8'(oa), 8'b00000);
        tick();

        // start and abort together in IDLE: abort wins
        start_a = 1'b1; abort = 1'b1; len = 4'd3;
        tick();
        start_a = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_idle c1", 8'(oa), 8'b00000);
        tick();

        // Abort asserted in cycle 4 of the basic sequence, restart in cycle 6
        for (int c = 0; c <= 5; c++) begin
            start_a = (c == 0);
            code    = 16'h0024;
            len     = 4'd3;
            abort   = (c == 4);
            @(negedge clk);
            chk($sformatf("abort out c%0d", c), 8'(oa), (c == 5) ? 8'h00 : 8'(basic_exp[c]));
            if (c == 5) chk("abort idx c5", 8'(idx_a), 8'd0);
            tick();
        end
        abort = 1'b0;
        run_basic("restart", 1'b0);

        // len above MAX_LEN clamps to 8 symbols: done at 1 + 8*2 + 7*1 = 24
        for (int c = 0; c <= 25; c++) begin
            start_a = (c == 0);
            code    = 16'h0000;
            len     = 4'd15;
            @(negedge clk);
            if (c == 23) begin
                chk("clamp c23", 8'(oa), 8'b10010);
                chk("clamp idx c23", 8'(idx_a), 8'd7);
            end
            if (c == 24) chk("clamp c24", 8'(oa), 8'b00001);
            if (c == 25) chk("clamp c25", 8'(oa), 8'b00000);
            tick();
        end
        start_a = 1'b0;

        // Reset in cycle 5, then reset together with start in cycle 7
        for (int c = 0; c <= 9; c++) begin
            start_a = (c == 0) || (c == 7);
            rst     = (c == 5) || (c == 7);
            code    = 16'h0024;
            len     = 4'd3;
            @(negedge clk);
            if (c == 4) chk("rst_mid c4", 8'(oa), 8'b01010);
            if (c == 6) chk("rst_mid c6", 8'(oa), 8'b00000);
            if (c == 6) chk("rst_mid idx c6", 8'(idx_a), 8'd0);
            if (c == 8) chk("rst_start c8", 8'(oa), 8'b00000);
            if (c == 9) chk("rst_start c9", 8'(oa), 8'b00000);
            tick();
        end
        rst = 1'b0; start_a = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
